// File: rtl/commit_unit_pkg.sv
// Shared types for the commit stage: ROB entry layout, status/op enums and commit FSM states.
package commit_unit_pkg;

  typedef enum logic [1:0] {empty, rob_wait, done} rob_status_t;

  typedef enum logic [2:0] {OP_ALU, OP_LOAD, OP_STORE, OP_BR, OP_JAL} op_t;

  typedef enum logic [1:0] {CS_RUN, CS_STORE_WAIT, CS_FLUSH_HOLD} commit_state_t;

  typedef struct packed {
    logic        valid;
    rob_status_t status;
    op_t         op;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        regf_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        br_en;
    logic        prediction;
    logic [31:0] pc_new;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rob_entry_t;

  function automatic logic is_ctrl(op_t op);
    return (op == OP_BR) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/commit_unit_if.sv
// ROB-head / retirement bus between the reorder buffer side and the commit unit.
interface commit_unit_if
  import commit_unit_pkg::*;
#(
  parameter int ROB_DEPTH = 32
);
  localparam int IDX_W = $clog2(ROB_DEPTH);

  rob_entry_t       rob_head_i;
  logic [IDX_W-1:0] rob_head_idx_i;
  logic             rob_empty_i;
  logic             dequeue_o;
  logic             flush_o;
  logic             regf_we_o;
  logic [4:0]       regf_rd_addr_o;
  logic [31:0]      regf_rd_data_o;
  logic [IDX_W-1:0] regf_rob_idx_o;
  logic             redirect_valid_o;
  logic [31:0]      redirect_pc_o;
  logic             bp_upd_valid_o;
  logic [31:0]      bp_upd_pc_o;
  logic             bp_upd_taken_o;
  logic             store_commit_o;
  logic [IDX_W-1:0] store_idx_o;
  logic             store_ack_i;
  logic [63:0]      retired_o;

  modport master (
    input  rob_head_i, rob_head_idx_i, rob_empty_i, store_ack_i,
    output dequeue_o, flush_o, regf_we_o, regf_rd_addr_o, regf_rd_data_o, regf_rob_idx_o,
           redirect_valid_o, redirect_pc_o, bp_upd_valid_o, bp_upd_pc_o, bp_upd_taken_o,
           store_commit_o, store_idx_o, retired_o
  );

  modport slave (
    output rob_head_i, rob_head_idx_i, rob_empty_i, store_ack_i,
    input  dequeue_o, flush_o, regf_we_o, regf_rd_addr_o, regf_rd_data_o, regf_rob_idx_o,
           redirect_valid_o, redirect_pc_o, bp_upd_valid_o, bp_upd_pc_o, bp_upd_taken_o,
           store_commit_o, store_idx_o, retired_o
  );

endinterface

// File: rtl/commit_rvfi_mon.sv
// Registered retirement monitor: captures each retired instruction one cycle after it retires.
module commit_rvfi_mon
  import commit_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        retire,
  input  logic [63:0] order,
  input  rob_entry_t  head,
  input  logic        rd_we,
  input  logic        flushed,
  input  logic [31:0] redirect_pc,
  output logic        rvfi_valid,
  output logic [63:0] rvfi_order,
  output logic [31:0] rvfi_insn,
  output logic [31:0] rvfi_pc_rdata,
  output logic [31:0] rvfi_pc_wdata,
  output logic [4:0]  rvfi_rs1_addr,
  output logic [4:0]  rvfi_rs2_addr,
  output logic [31:0] rvfi_rs1_rdata,
  output logic [31:0] rvfi_rs2_rdata,
  output logic [4:0]  rvfi_rd_addr,
  output logic [31:0] rvfi_rd_wdata,
  output logic [31:0] rvfi_mem_addr,
  output logic [3:0]  rvfi_mem_rmask,
  output logic [3:0]  rvfi_mem_wmask,
  output logic [31:0] rvfi_mem_rdata,
  output logic [31:0] rvfi_mem_wdata
);

  logic unused_fields;
  assign unused_fields = ^{head.valid, head.status, head.op, head.regf_we,
                           head.br_en, head.prediction, head.pc_new};

  // retire edge -> monitor stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvfi_valid     <= 1'b0;
      rvfi_order     <= '0;
      rvfi_insn      <= '0;
      rvfi_pc_rdata  <= '0;
      rvfi_pc_wdata  <= '0;
      rvfi_rs1_addr  <= '0;
      rvfi_rs2_addr  <= '0;
      rvfi_rs1_rdata <= '0;
      rvfi_rs2_rdata <= '0;
      rvfi_rd_addr   <= '0;
      rvfi_rd_wdata  <= '0;
      rvfi_mem_addr  <= '0;
      rvfi_mem_rmask <= '0;
      rvfi_mem_wmask <= '0;
      rvfi_mem_rdata <= '0;
      rvfi_mem_wdata <= '0;
    end else begin
      rvfi_valid <= retire;
      if (retire) begin
        rvfi_order     <= order;
        rvfi_insn      <= head.insn;
        rvfi_pc_rdata  <= head.pc;
        rvfi_pc_wdata  <= flushed ? redirect_pc : head.pc + 32'd4;
        rvfi_rs1_addr  <= head.rs1_addr;
        rvfi_rs2_addr  <= head.rs2_addr;
        rvfi_rs1_rdata <= head.rs1_data;
        rvfi_rs2_rdata <= head.rs2_data;
        rvfi_rd_addr   <= rd_we ? head.rd_addr : 5'd0;
        rvfi_rd_wdata  <= rd_we ? head.rd_data : 32'd0;
        rvfi_mem_addr  <= head.mem_addr;
        rvfi_mem_rmask <= head.mem_rmask;
        rvfi_mem_wmask <= head.mem_wmask;
        rvfi_mem_rdata <= head.mem_rdata;
        rvfi_mem_wdata <= head.mem_wdata;
      end
    end
  end

endmodule

// File: rtl/commit_unit.sv
// In-order retirement stage on the ROB read side; sole source of dequeue and flush.
// Optional retirement monitor ports are built when COMMIT_RVFI_EN is defined.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int ROB_DEPTH    = 32,
  parameter int FLUSH_CYCLES = 2
)(
  input  logic          clk,
  input  logic          rst_n,
  commit_unit_if.master cu
`ifdef COMMIT_RVFI_EN
  ,
  output logic          rvfi_valid,
  output logic [63:0]   rvfi_order,
  output logic [31:0]   rvfi_insn,
  output logic [31:0]   rvfi_pc_rdata,
  output logic [31:0]   rvfi_pc_wdata,
  output logic [4:0]    rvfi_rs1_addr,
  output logic [4:0]    rvfi_rs2_addr,
  output logic [31:0]   rvfi_rs1_rdata,
  output logic [31:0]   rvfi_rs2_rdata,
  output logic [4:0]    rvfi_rd_addr,
  output logic [31:0]   rvfi_rd_wdata,
  output logic [31:0]   rvfi_mem_addr,
  output logic [3:0]    rvfi_mem_rmask,
  output logic [3:0]    rvfi_mem_wmask,
  output logic [31:0]   rvfi_mem_rdata,
  output logic [31:0]   rvfi_mem_wdata
`endif
);

  localparam int IDX_W = $clog2(ROB_DEPTH);

  commit_state_t    state;
  logic [3:0]       hold_cnt;
  logic [IDX_W-1:0] store_idx_q;
  logic [63:0]      retired_q;

  rob_entry_t       head;
  logic             ready, mispredict;
  logic             dequeue, flush, regf_we, redirect_valid, bp_upd_valid, bp_upd_taken, store_commit;
  logic [4:0]       rd_addr;
  logic [31:0]      rd_data, redirect_pc, bp_upd_pc;
  logic [IDX_W-1:0] regf_rob_idx, store_idx;

  assign head       = cu.rob_head_i;
  assign ready      = !cu.rob_empty_i && head.valid && (head.status == done);
  assign mispredict = is_ctrl(head.op) && (head.br_en != head.prediction);

  // Strobes are combinational and forced low while reset is asserted.
  always_comb begin
    dequeue        = 1'b0;
    flush          = 1'b0;
    regf_we        = 1'b0;
    rd_addr        = '0;
    rd_data        = '0;
    regf_rob_idx   = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bp_upd_valid   = 1'b0;
    bp_upd_pc      = '0;
    bp_upd_taken   = 1'b0;
    store_commit   = 1'b0;
    store_idx      = '0;
    if (rst_n) begin
      case (state)
        CS_RUN: begin
          if (ready) begin
            if (head.op == OP_STORE) begin
              store_commit = 1'b1;
              store_idx    = cu.rob_head_idx_i;
              dequeue      = cu.store_ack_i;
            end else begin
              if (head.regf_we && head.rd_addr != 5'd0) begin
                regf_we      = 1'b1;
                rd_addr      = head.rd_addr;
                rd_data      = head.rd_data;
                regf_rob_idx = cu.rob_head_idx_i;
              end
              if (head.op == OP_BR) begin
                bp_upd_valid = 1'b1;
                bp_upd_pc    = head.pc;
                bp_upd_taken = head.br_en;
              end
              if (mispredict) begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = head.br_en ? head.pc_new : head.pc + 32'd4;
              end else begin
                dequeue = 1'b1;
              end
            end
          end
        end
        CS_STORE_WAIT: begin
          store_commit = 1'b1;
          store_idx    = store_idx_q;
          dequeue      = cu.store_ack_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CS_RUN;
      hold_cnt    <= '0;
      store_idx_q <= '0;
      retired_q   <= '0;
    end else begin
      if (dequeue || flush) retired_q <= retired_q + 64'd1;
      case (state)
        CS_RUN: begin
          if (flush) begin
            state    <= CS_FLUSH_HOLD;
            hold_cnt <= 4'(FLUSH_CYCLES);
          end else if (store_commit && !dequeue) begin
            state       <= CS_STORE_WAIT;
            store_idx_q <= cu.rob_head_idx_i;
          end
        end
        CS_STORE_WAIT: if (dequeue) state <= CS_RUN;
        CS_FLUSH_HOLD: begin
          if (hold_cnt <= 4'd1) state <= CS_RUN;
          else                  hold_cnt <= hold_cnt - 4'd1;
        end
        default: state <= CS_RUN;
      endcase
    end
  end

  assign cu.dequeue_o        = dequeue;
  assign cu.flush_o          = flush;
  assign cu.regf_we_o        = regf_we;
  assign cu.regf_rd_addr_o   = rd_addr;
  assign cu.regf_rd_data_o   = rd_data;
  assign cu.regf_rob_idx_o   = regf_rob_idx;
  assign cu.redirect_valid_o = redirect_valid;
  assign cu.redirect_pc_o    = redirect_pc;
  assign cu.bp_upd_valid_o   = bp_upd_valid;
  assign cu.bp_upd_pc_o      = bp_upd_pc;
  assign cu.bp_upd_taken_o   = bp_upd_taken;
  assign cu.store_commit_o   = store_commit;
  assign cu.store_idx_o      = store_idx;
  assign cu.retired_o        = retired_q;

`ifdef COMMIT_RVFI_EN
  commit_rvfi_mon u_rvfi_mon (
    .clk            (clk),
    .rst_n          (rst_n),
    .retire         (dequeue || flush),
    .order          (retired_q),
    .head           (head),
    .rd_we          (regf_we),
    .flushed        (flush),
    .redirect_pc    (redirect_pc),
    .rvfi_valid     (rvfi_valid),
    .rvfi_order     (rvfi_order),
    .rvfi_insn      (rvfi_insn),
    .rvfi_pc_rdata  (rvfi_pc_rdata),
    .rvfi_pc_wdata  (rvfi_pc_wdata),
    .rvfi_rs1_addr  (rvfi_rs1_addr),
    .rvfi_rs2_addr  (rvfi_rs2_addr),
    .rvfi_rs1_rdata (rvfi_rs1_rdata),
    .rvfi_rs2_rdata (rvfi_rs2_rdata),
    .rvfi_rd_addr   (rvfi_rd_addr),
    .rvfi_rd_wdata  (rvfi_rd_wdata),
    .rvfi_mem_addr  (rvfi_mem_addr),
    .rvfi_mem_rmask (rvfi_mem_rmask),
    .rvfi_mem_wmask (rvfi_mem_wmask),
    .rvfi_mem_rdata (rvfi_mem_rdata),
    .rvfi_mem_wdata (rvfi_mem_wdata)
  );
`else
  logic unused_head;
  assign unused_head = ^{head.insn, head.rs1_addr, head.rs2_addr, head.rs1_data, head.rs2_data,
                         head.mem_addr, head.mem_rmask, head.mem_wmask, head.mem_rdata, head.mem_wdata};
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: vector table for single-cycle retire cases plus
// hand sequences for mispredict hold, delayed store ack, reset in STORE_WAIT and back-to-back.
module tb_commit_unit;
  import commit_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [63:0] exp_ret = '0;

  always #5 clk = ~clk;

  commit_unit_if #(.ROB_DEPTH(32)) bus ();

  commit_unit #(.ROB_DEPTH(32), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cu    (bus)
  );

  typedef struct {
    rob_entry_t  e;
    logic [4:0]  idx;
    logic        emp;
    logic        ack;
    logic        x_deq;
    logic        x_we;
    logic [4:0]  x_rd;
    logic [31:0] x_data;
    logic        x_bp;
    logic        x_taken;
    logic        x_sc;
  } vec_t;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic rob_entry_t ent(op_t op, rob_status_t st, logic vld, logic [4:0] rd,
                                     logic we, logic [31:0] data, logic [31:0] pc,
                                     logic br_en, logic pred, logic [31:0] pc_new);
    rob_entry_t e;
    e            = '0;
    e.valid      = vld;
    e.status     = st;
    e.op         = op;
    e.rd_addr    = rd;
    e.regf_we    = we;
    e.rd_data    = data;
    e.pc         = pc;
    e.br_en      = br_en;
    e.prediction = pred;
    e.pc_new     = pc_new;
    return e;
  endfunction

  function automatic vec_t mkv(rob_entry_t e, logic [4:0] idx, logic emp, logic ack,
                               logic xd, logic xw, logic [4:0] xr, logic [31:0] xdat,
                               logic xbp, logic xt, logic xsc);
    vec_t v;
    v.e = e; v.idx = idx; v.emp = emp; v.ack = ack;
    v.x_deq = xd; v.x_we = xw; v.x_rd = xr; v.x_data = xdat;
    v.x_bp = xbp; v.x_taken = xt; v.x_sc = xsc;
    return v;
  endfunction

  task automatic drive(rob_entry_t e, logic [4:0] idx, logic emp, logic ack);
    bus.rob_head_i     = e;
    bus.rob_head_idx_i = idx;
    bus.rob_empty_i    = emp;
    bus.store_ack_i    = ack;
  endtask

  task automatic run_mispredict(string tag, rob_entry_t e, logic [31:0] x_pc, logic x_we, logic x_bp);
    drive(e, 5'd3, 1'b0, 1'b0);
    #4;
    chk($sformatf("%s_flush", tag), bus.flush_o, 1'b1);
    chk($sformatf("%s_deq", tag), bus.dequeue_o, 1'b0);
    chk($sformatf("%s_redir_v", tag), bus.redirect_valid_o, 1'b1);
    chk($sformatf("%s_redir_pc", tag), bus.redirect_pc_o, x_pc);
    chk($sformatf("%s_link_we", tag), bus.regf_we_o, x_we);
    chk($sformatf("%s_bp", tag), bus.bp_upd_valid_o, x_bp);
    exp_ret++;
    step();
    chk($sformatf("%s_ret", tag), bus.retired_o, exp_ret);
    // done ALU head with a stray ack during the blackout
    drive(ent(OP_ALU, done, 1'b1, 5'd2, 1'b1, 32'h55, 32'h1100, 1'b0, 1'b0, 32'h0), 5'd4, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #4;
      chk($sformatf("%s_hold%0d_deq", tag, c), bus.dequeue_o, 1'b0);
      chk($sformatf("%s_hold%0d_we", tag, c), bus.regf_we_o, 1'b0);
      chk($sformatf("%s_hold%0d_flush", tag, c), bus.flush_o, 1'b0);
      step();
    end
    #4;
    chk($sformatf("%s_resume_deq", tag), bus.dequeue_o, 1'b1);
    exp_ret++;
    step();
    chk($sformatf("%s_resume_ret", tag), bus.retired_o, exp_ret);
  endtask

  vec_t vt[12];
  int   deq_cnt;

  initial begin
    vt[0]  = mkv(ent(OP_ALU, done, 1, 5'd5, 1, 32'h1234, 32'h10, 0, 0, 0), 5'd0, 0, 0, 1, 1, 5'd5, 32'h1234, 0, 0, 0);
    vt[1]  = mkv(ent(OP_ALU, done, 1, 5'd0, 1, 32'hAAAA, 32'h14, 0, 0, 0), 5'd1, 0, 0, 1, 0, 5'd0, 32'h0, 0, 0, 0);
    vt[2]  = mkv(ent(OP_ALU, done, 1, 5'd3, 0, 32'hBBBB, 32'h18, 0, 0, 0), 5'd2, 0, 0, 1, 0, 5'd0, 32'h0, 0, 0, 0);
    vt[3]  = mkv(ent(OP_ALU, rob_wait, 1, 5'd6, 1, 32'h1, 32'h1C, 0, 0, 0), 5'd3, 0, 0, 0, 0, 5'd0, 32'h0, 0, 0, 0);
    vt[4]  = mkv(ent(OP_ALU, done, 1, 5'd6, 1, 32'h1, 32'h1C, 0, 0, 0), 5'd3, 1, 0, 0, 0, 5'd0, 32'h0, 0, 0, 0);
    vt[5]  = mkv(ent(OP_ALU, done, 0, 5'd6, 1, 32'h1, 32'h1C, 0, 0, 0), 5'd3, 0, 0, 0, 0, 5'd0, 32'h0, 0, 0, 0);
    vt[6]  = mkv(ent(OP_BR, done, 1, 5'd0, 0, 32'h0, 32'h40, 1, 1, 32'h80), 5'd4, 0, 0, 1, 0, 5'd0, 32'h0, 1, 1, 0);
    vt[7]  = mkv(ent(OP_BR, done, 1, 5'd0, 0, 32'h0, 32'h44, 0, 0, 32'h90), 5'd5, 0, 0, 1, 0, 5'd0, 32'h0, 1, 0, 0);
    vt[8]  = mkv(ent(OP_JAL, done, 1, 5'd1, 1, 32'h4C, 32'h48, 1, 1, 32'h200), 5'd6, 0, 0, 1, 1, 5'd1, 32'h4C, 0, 0, 0);
    vt[9]  = mkv(ent(OP_STORE, done, 1, 5'd0, 0, 32'h0, 32'h50, 0, 0, 0), 5'd9, 0, 1, 1, 0, 5'd0, 32'h0, 0, 0, 1);
    vt[10] = mkv(ent(OP_LOAD, done, 1, 5'd10, 1, 32'hDEAD, 32'h54, 0, 0, 0), 5'd10, 0, 0, 1, 1, 5'd10, 32'hDEAD, 0, 0, 0);
    vt[11] = mkv(ent(OP_STORE, rob_wait, 1, 5'd0, 0, 32'h0, 32'h58, 0, 0, 0), 5'd11, 0, 1, 0, 0, 5'd0, 32'h0, 0, 0, 0);

    // reset state with a ready head present
    drive(ent(OP_ALU, done, 1, 5'd5, 1, 32'h1234, 32'h10, 0, 0, 0), 5'd0, 1'b0, 1'b1);
    #12;
    chk("rst_deq", bus.dequeue_o, 1'b0);
    chk("rst_we", bus.regf_we_o, 1'b0);
    chk("rst_ret", bus.retired_o, 64'd0);
    rst_n = 1'b1;
    step();
    exp_ret = 64'd1;
    chk("rst_first_ret", bus.retired_o, exp_ret);

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].e, vt[i].idx, vt[i].emp, vt[i].ack);
      #4;
      chk($sformatf("v%0d_deq", i), bus.dequeue_o, vt[i].x_deq);
      chk($sformatf("v%0d_flush", i), bus.flush_o, 1'b0);
      chk($sformatf("v%0d_we", i), bus.regf_we_o, vt[i].x_we);
      chk($sformatf("v%0d_rd", i), bus.regf_rd_addr_o, vt[i].x_rd);
      chk($sformatf("v%0d_data", i), bus.regf_rd_data_o, vt[i].x_data);
      chk($sformatf("v%0d_robidx", i), bus.regf_rob_idx_o, vt[i].x_we ? vt[i].idx : 5'd0);
      chk($sformatf("v%0d_bp", i), bus.bp_upd_valid_o, vt[i].x_bp);
      chk($sformatf("v%0d_bp_pc", i), bus.bp_upd_pc_o, vt[i].x_bp ? vt[i].e.pc : 32'd0);
      chk($sformatf("v%0d_bp_taken", i), bus.bp_upd_taken_o, vt[i].x_taken);
      chk($sformatf("v%0d_sc", i), bus.store_commit_o, vt[i].x_sc);
      chk($sformatf("v%0d_sidx", i), bus.store_idx_o, vt[i].x_sc ? vt[i].idx : 5'd0);
      if (vt[i].x_deq) exp_ret++;
      step();
      chk($sformatf("v%0d_ret", i), bus.retired_o, exp_ret);
    end

    run_mispredict("mp_taken", ent(OP_BR, done, 1, 5'd0, 0, 32'h0, 32'h1000, 1, 0, 32'h2000), 32'h2000, 1'b0, 1'b1);
    run_mispredict("mp_ntaken", ent(OP_BR, done, 1, 5'd0, 0, 32'h0, 32'h1000, 0, 1, 32'h2000), 32'h1004, 1'b0, 1'b1);
    run_mispredict("mp_jal", ent(OP_JAL, done, 1, 5'd1, 1, 32'h3004, 32'h3000, 1, 0, 32'h4000), 32'h4000, 1'b1, 1'b0);

    // store at index 31, ack three cycles later; head index moves to show the held index
    for (int c = 0; c < 4; c++) begin
      drive(ent(OP_STORE, done, 1, 5'd0, 0, 32'h0, 32'h60, 0, 0, 0), (c == 0) ? 5'd31 : 5'd5, 1'b0, (c == 3));
      #4;
      chk($sformatf("st%0d_sc", c), bus.store_commit_o, 1'b1);
      chk($sformatf("st%0d_idx", c), bus.store_idx_o, 5'd31);
      chk($sformatf("st%0d_deq", c), bus.dequeue_o, (c == 3));
      step();
    end
    exp_ret++;
    chk("st_ret", bus.retired_o, exp_ret);

    // reset pulse while waiting on a store ack
    drive(ent(OP_STORE, done, 1, 5'd0, 0, 32'h0, 32'h70, 0, 0, 0), 5'd7, 1'b0, 1'b0);
    step();
    #1;
    chk("rw_pre_sc", bus.store_commit_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rw_sc", bus.store_commit_o, 1'b0);
    chk("rw_sidx", bus.store_idx_o, 5'd0);
    chk("rw_deq", bus.dequeue_o, 1'b0);
    chk("rw_ret", bus.retired_o, 64'd0);
    rst_n = 1'b1;
    exp_ret = '0;
    #1;
    chk("rw_re_sc", bus.store_commit_o, 1'b1);
    chk("rw_re_idx", bus.store_idx_o, 5'd7);
    chk("rw_re_deq", bus.dequeue_o, 1'b0);
    step();
    bus.store_ack_i = 1'b1;
    #4;
    chk("rw_ack_deq", bus.dequeue_o, 1'b1);
    exp_ret++;
    step();
    chk("rw_ack_ret", bus.retired_o, exp_ret);

    // 32 back-to-back ALU retires, index wrapping 31 -> 0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    deq_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      drive(ent(OP_ALU, done, 1, 5'd4, 1, 32'(k), 32'h100, 0, 0, 0), 5'((k + 16) % 32), 1'b0, 1'b0);
      #3;
      if (bus.dequeue_o) deq_cnt++;
      step();
    end
    chk("b2b_deq_cnt", 64'(deq_cnt), 64'd32);
    chk("b2b_ret", bus.retired_o, 64'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
